card_display_ctrl: RTL and testbench
====================================

// Module: card_display_ctrl
// PURPOSE
//  Registered N-slot card display controller for the baccarat datapath; replaces per-digit combinational decode.
//  Each slot captures a 4-bit card code on load and decodes it to an active-low 7-seg pattern.
//  A newly loaded card blinks for a fixed number of half-periods, then stays steady ("reveal" effect).
//  Sits between datapath card registers (3 player + 3 dealer) and the HEX outputs.
// PARAMETERS
//  N_SLOTS      6   number of independent card digits
//  TICK_DIV     25  clock cycles per blink half-period tick (global prescaler); >=2
//  BLINK_HALVES 6   half-periods of blink after a load (even, >=2); 0 disables blink
// PORTS
//  fast_clock  in   1          single clock, all logic rising-edge
//  resetb      in   1          asynchronous active-low reset
//  clear       in   1          sync clear: all slots blank, blink aborted
//  load        in   N_SLOTS    per-slot capture strobe, 1 cycle
//  card_in     in   N_SLOTS*4  packed card codes, slot i = [4i+3:4i]
//  seg7        out  N_SLOTS*7  registered active-low segments, slot i = [7i+6:7i]
//  busy        out  1          high while any slot is in BLINK
//  card_q      out  N_SLOTS*4  captured card codes (for score logic)
// BEHAVIOUR
//  Reset (resetb=0, async): all seg7 bits 1 (blank), card_q=0, busy=0, all slots IDLE, prescaler=0.
//  Card codes: 0 blank, 1 A, 2-9 digits, 10 "0", 11 J, 12 Q, 13 K, 14/15 unused -> blank.
//  Prescaler: counts 0..TICK_DIV-1, tick asserted for 1 cycle at TICK_DIV-1, wraps to 0; free-running.
//  Slot FSM, states IDLE / BLINK / SHOW:
//   load & card_in==0        -> IDLE, card_q=0.
//   load & card_in!=0        -> BLINK, card_q=card_in, phase=ON, halves=BLINK_HALVES (SHOW if BLINK_HALVES=0).
//   BLINK: on tick phase toggles, halves-=1; when halves reaches 0 -> SHOW (phase ON).
//   load in BLINK/SHOW       -> restart per above (relaunch blink with new code).
//   clear (any state)        -> IDLE, card_q=0; clear beats load in the same cycle.
//  First half-period lasts 1..TICK_DIV cycles (aligned to global tick); later ones exactly TICK_DIV.
//  seg7 registered: slot IDLE -> blank; SHOW or BLINK&ON -> decode(card_q); BLINK&OFF -> blank.
//  Latency: load sampled at edge k -> card_q valid after k, seg7 shows code after edge k+1.
//  busy registered alongside seg7 (same cycle alignment).
//  Load and tick in same cycle: load wins, halves reloaded, phase ON.
//  Slots fully independent; simultaneous loads on several slots all accepted.
// CONFIGURATION
//  CARDDISP_ERRCHK_EN defined: codes 14/15 display "E" (7'b0000110) instead of blank, still blink;
//   extra port err out 1: sticky, set when a load captures 14/15, cleared only by clear or reset.
//  Undefined: no err port, 14/15 blank, FSM identical.
// STRUCTURE
//  Package card_display_pkg: typedef card_t (logic[3:0]), seg_t (logic[6:0]), slot_state_e enum,
//   SEG_* localparam patterns (blank/A..K/E), function automatic seg_t card_to_seg(card_t).
//  Sub-module card_slot (one instance per slot via generate): FSM, halves counter, seg7 register.
//  Top holds prescaler, busy OR-reduce, optional err.
// TESTING
//  1 reset mid-blink: assert resetb=0 async -> seg7 all 7'h7F, busy=0 same cycle, no clock needed.
//  2 load slot0 code 1, TICK_DIV=4, BLINK_HALVES=4 -> 7'b0001000, blank, A, blank, then steady A; busy drops.
//  3 load slot2 code 13 then code 12 mid-blink -> restart, full 4 halves, final steady 7'b0011000.
//  4 clear and load same cycle on slot1 -> slot1 blank, card_q[7:4]=0, busy=0.
//  5 load code 0 and code 10 on slots 3/4 together -> slot3 blank no busy; slot4 blinks "0" 7'b1000000.
//  6 ERRCHK_EN: load code 15 -> seg7 7'b0000110 blinks, err=1 stays set after SHOW; clear -> err=0.

Source files
------------

// File: rtl/card_display_pkg.sv
// Card display shared types, 7-seg patterns and decode.
// CARDDISP_ERRCHK_EN: codes 14/15 decode to "E" instead of blank.
package card_display_pkg;

    typedef logic [3:0] card_t;
    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        BLINK,
        SHOW
    } slot_state_e;

    // Active-low, bit order gfedcba
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_J     = 7'b1100001;
    localparam seg_t SEG_Q     = 7'b0011000;
    localparam seg_t SEG_K     = 7'b0001001;
    localparam seg_t SEG_E     = 7'b0000110;

    function automatic seg_t card_to_seg(card_t c);
        seg_t s;
        case (c)
            4'd1:    s = SEG_A;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            4'd10:   s = SEG_0;
            4'd11:   s = SEG_J;
            4'd12:   s = SEG_Q;
            4'd13:   s = SEG_K;
`ifdef CARDDISP_ERRCHK_EN
            4'd14,
            4'd15:   s = SEG_E;
`endif
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/card_display_ctrl_slot.sv
// One card digit: capture, blink-then-show FSM, registered segments.
// Decode of codes 14/15 depends on CARDDISP_ERRCHK_EN (see package).
module card_slot
    import card_display_pkg::*;
#(
    parameter int BLINK_HALVES = 6
) (
    input  logic  fast_clock,
    input  logic  resetb,
    input  logic  clear,
    input  logic  tick,
    input  logic  load,
    input  card_t card_in,
    output seg_t  seg7,
    output logic  busy,
    output card_t card_q
);

    localparam int HW = (BLINK_HALVES > 1) ? $clog2(BLINK_HALVES + 1) : 1;

    slot_state_e   state, state_n;
    logic          phase, phase_n;
    logic [HW-1:0] halves, halves_n;
    card_t         card_n;
    seg_t          seg_n;
    logic          busy_n;

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            state  <= IDLE;
            phase  <= 1'b1;
            halves <= '0;
            card_q <= '0;
            seg7   <= SEG_BLANK;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            halves <= halves_n;
            card_q <= card_n;
            seg7   <= seg_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        halves_n = halves;
        card_n   = card_q;
        if (clear) begin
            state_n  = IDLE;
            phase_n  = 1'b1;
            halves_n = '0;
            card_n   = '0;
        end else if (load) begin
            phase_n  = 1'b1;
            halves_n = HW'(BLINK_HALVES);
            card_n   = card_in;
            if (card_in == '0) begin
                state_n  = IDLE;
                halves_n = '0;
            end else if (BLINK_HALVES == 0) begin
                state_n = SHOW;
            end else begin
                state_n = BLINK;
            end
        end else if (state == BLINK && tick) begin
            // Last half-period ends on the phase that was just shown
            if (halves == HW'(1)) begin
                state_n  = SHOW;
                phase_n  = 1'b1;
                halves_n = '0;
            end else begin
                phase_n  = ~phase;
                halves_n = halves - HW'(1);
            end
        end
    end

    always_comb begin
        seg_n  = SEG_BLANK;
        busy_n = (state == BLINK);
        unique case (state)
            BLINK:   seg_n = phase ? card_to_seg(card_q) : SEG_BLANK;
            SHOW:    seg_n = card_to_seg(card_q);
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/card_display_ctrl.sv
// N-slot registered card display with shared blink prescaler.
// CARDDISP_ERRCHK_EN adds sticky err output for codes 14/15.
module card_display_ctrl
    import card_display_pkg::*;
#(
    parameter int N_SLOTS      = 6,
    parameter int TICK_DIV     = 25,
    parameter int BLINK_HALVES = 6
) (
    input  logic                 fast_clock,
    input  logic                 resetb,
    input  logic                 clear,
    input  logic [N_SLOTS-1:0]   load,
    input  logic [N_SLOTS*4-1:0] card_in,
    output logic [N_SLOTS*7-1:0] seg7,
    output logic                 busy,
    output logic [N_SLOTS*4-1:0] card_q
`ifdef CARDDISP_ERRCHK_EN
    ,
    output logic                 err
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]      presc;
    logic               tick;
    logic [N_SLOTS-1:0] busy_s;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb)   presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        card_slot #(
            .BLINK_HALVES(BLINK_HALVES)
        ) u_slot (
            .fast_clock(fast_clock),
            .resetb    (resetb),
            .clear     (clear),
            .tick      (tick),
            .load      (load[i]),
            .card_in   (card_in[4*i +: 4]),
            .seg7      (seg7[7*i +: 7]),
            .busy      (busy_s[i]),
            .card_q    (card_q[4*i +: 4])
        );
    end

    assign busy = |busy_s;

`ifdef CARDDISP_ERRCHK_EN
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (load[i] && card_in[4*i +: 4] >= 4'd14) err_set = 1'b1;
        end
    end

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb)      err <= 1'b0;
        else if (clear)   err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_card_display_ctrl.sv
// Scoreboard bench for card_display_ctrl (TICK_DIV=4, BLINK_HALVES=4).
// Build with CARDDISP_ERRCHK_EN to also cover the err port.
module tb_card_display_ctrl;

    logic        fast_clock = 1'b0;
    logic        resetb     = 1'b0;
    logic        clear      = 1'b0;
    logic [5:0]  load       = '0;
    logic [23:0] card_in    = '0;
    logic [41:0] seg7;
    logic        busy;
    logic [23:0] card_q;
`ifdef CARDDISP_ERRCHK_EN
    logic        err;
    localparam logic [6:0] EV = 7'b0000110;
`else
    localparam logic [6:0] EV = 7'b1111111;
`endif

    localparam logic [6:0] BL = 7'b1111111;

    card_display_ctrl #(
        .N_SLOTS     (6),
        .TICK_DIV    (4),
        .BLINK_HALVES(4)
    ) dut (
        .fast_clock(fast_clock),
        .resetb    (resetb),
        .clear     (clear),
        .load      (load),
        .card_in   (card_in),
        .seg7      (seg7),
        .busy      (busy),
        .card_q    (card_q)
`ifdef CARDDISP_ERRCHK_EN
        ,
        .err       (err)
`endif
    );

    always #5 fast_clock = ~fast_clock;

    typedef struct packed {
        int         cyc;
        int         slot;
        logic [6:0] seg;
        logic       busy;
        logic [3:0] cq;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge fast_clock or negedge resetb) begin
        if (!resetb) cyc = 0;
        else         cyc = cyc + 1;
    end

    task automatic push(input int c, input int s, input logic [6:0] sg,
                        input logic b, input logic [3:0] q);
        exp_t e;
        e.cyc  = c;
        e.slot = s;
        e.seg  = sg;
        e.busy = b;
        e.cq   = q;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge fast_clock);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge fast_clock) begin
        if (resetb) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                logic [6:0] gs;
                logic [3:0] gq;
                e  = sb.pop_front();
                gs = seg7[e.slot*7 +: 7];
                gq = card_q[e.slot*4 +: 4];
                n_chk++;
                if (e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL sb missed slot%0d cyc%0d now%0d", e.slot, e.cyc, cyc);
                end else if (gs !== e.seg || busy !== e.busy || gq !== e.cq) begin
                    n_fail++;
                    $display("FAIL sb slot%0d cyc%0d seg=%b busy=%b cq=%0d expected seg=%b busy=%b cq=%0d",
                             e.slot, cyc, gs, busy, gq, e.seg, e.busy, e.cq);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #10;
        chk("rst_seg", 64'(seg7), 64'({42{1'b1}}));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cq", 64'(card_q), 64'(0));
        #12 resetb = 1'b1;

        // slot0 code 1: ticks at edges 4,8,12,16
        wait_cyc(1);
        load[0] = 1'b1;
        card_in[3:0] = 4'd1;
        push(2, 0, BL, 0, 1);
        push(3, 0, 7'b0001000, 1, 1);
        push(4, 0, 7'b0001000, 1, 1);
        push(5, 0, BL, 1, 1);
        push(8, 0, BL, 1, 1);
        push(9, 0, 7'b0001000, 1, 1);
        push(13, 0, BL, 1, 1);
        push(16, 0, BL, 1, 1);
        push(17, 0, 7'b0001000, 0, 1);
        push(20, 0, 7'b0001000, 0, 1);
        wait_cyc(2);
        load = '0;

        // slot2 K then Q mid-blink
        wait_cyc(21);
        load[2] = 1'b1;
        card_in[11:8] = 4'd13;
        push(23, 2, 7'b0001001, 1, 13);
        push(25, 2, BL, 1, 13);
        push(26, 2, BL, 1, 12);
        push(27, 2, 7'b0011000, 1, 12);
        push(28, 2, 7'b0011000, 1, 12);
        push(29, 2, BL, 1, 12);
        push(33, 2, 7'b0011000, 1, 12);
        push(37, 2, BL, 1, 12);
        push(40, 2, BL, 1, 12);
        push(41, 2, 7'b0011000, 0, 12);
        wait_cyc(22);
        load = '0;
        wait_cyc(25);
        load[2] = 1'b1;
        card_in[11:8] = 4'd12;
        wait_cyc(26);
        load = '0;

        // clear beats load on slot1
        wait_cyc(43);
        clear   = 1'b1;
        load[1] = 1'b1;
        card_in[7:4] = 4'd5;
        push(44, 0, 7'b0001000, 0, 0);
        push(44, 1, BL, 0, 0);
        push(45, 0, BL, 0, 0);
        push(45, 1, BL, 0, 0);
        wait_cyc(44);
        clear = 1'b0;
        load  = '0;

        // slot3 code 0, slot4 code 10 together
        wait_cyc(49);
        load[3] = 1'b1;
        load[4] = 1'b1;
        card_in[15:12] = 4'd0;
        card_in[19:16] = 4'd10;
        push(51, 3, BL, 1, 0);
        push(51, 4, 7'b1000000, 1, 10);
        push(53, 4, BL, 1, 10);
        push(57, 4, 7'b1000000, 1, 10);
        push(61, 4, BL, 1, 10);
        push(65, 4, 7'b1000000, 0, 10);
        wait_cyc(50);
        load = '0;

        // slot5 code 15: "E" or blank, blinks either way
        wait_cyc(69);
`ifdef CARDDISP_ERRCHK_EN
        chk("err_pre", 64'(err), 64'(0));
`endif
        load[5] = 1'b1;
        card_in[23:20] = 4'd15;
        push(70, 5, BL, 0, 15);
        push(71, 5, EV, 1, 15);
        push(73, 5, BL, 1, 15);
        push(77, 5, EV, 1, 15);
        push(81, 5, BL, 1, 15);
        push(84, 5, BL, 1, 15);
        push(85, 5, EV, 0, 15);
        push(88, 5, EV, 0, 0);
        push(89, 5, BL, 0, 0);
        wait_cyc(70);
        load = '0;
`ifdef CARDDISP_ERRCHK_EN
        chk("err_set", 64'(err), 64'(1));
        wait_cyc(86);
        chk("err_sticky", 64'(err), 64'(1));
`endif
        wait_cyc(87);
        clear = 1'b1;
        wait_cyc(88);
        clear = 1'b0;
`ifdef CARDDISP_ERRCHK_EN
        chk("err_clr", 64'(err), 64'(0));
`endif

        // async reset mid-blink
        wait_cyc(91);
        load[0] = 1'b1;
        card_in[3:0] = 4'd7;
        push(93, 0, 7'b1111000, 1, 7);
        wait_cyc(92);
        load = '0;
        wait_cyc(94);
        resetb = 1'b0;
        #1;
        chk("arst_seg", 64'(seg7), 64'({42{1'b1}}));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_cq", 64'(card_q), 64'(0));

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL sb unchecked slot%0d cyc%0d", e.slot, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
